// File: rtl/lzd_norm_stage_pkg.sv
// ============================================================================
// Module  : lzd_norm_stage_pkg
// Purpose : Shared definitions for the post-adder normalization stage.
//           Default significand and shift-count widths, the normalization
//           result record, and the shift-count width helper.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

package lzd_norm_stage_pkg;

   localparam int SWR_DEFAULT = 26;
   localparam int EWR_DEFAULT = 5;

   // One normalized result at the default widths
   typedef struct packed {
      logic [SWR_DEFAULT-1:0] norm_sum;
      logic [EWR_DEFAULT-1:0] lz_count;
      logic                   shift_right;
      logic                   zero;
      logic                   sticky;
   } norm_res_t;

   // Bits needed to hold a count in 0..swr (swr itself flags an all-zero word)
   function automatic int lz_count_width(input int swr);
      return $clog2(swr + 1);
   endfunction

endpackage

`default_nettype wire

// File: rtl/lzd_norm_stage_count.sv
// ============================================================================
// Module  : lzd_count
// Purpose : Combinational leading-zero priority encoder.
// Ports   : data_i  [SWR-1:0]  word to scan, MSB first
//           count_o [EWR-1:0]  leading zeros from bit SWR-1 (SWR if all zero)
//           zero_o             data_i is all zero
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module lzd_count #(
   parameter int SWR = 26,
   parameter int EWR = 5
) (
   input  logic [SWR-1:0] data_i,
   output logic [EWR-1:0] count_o,
   output logic           zero_o
);

   // Scan upward so the highest set bit is the last (winning) assignment
   always_comb begin
      count_o = EWR'(SWR);
      for (int i = 0; i < SWR; i++) begin
         if (data_i[i]) begin
            count_o = EWR'(SWR - 1 - i);
         end
      end
   end

   assign zero_o = ~|data_i;

endmodule

`default_nettype wire

// File: rtl/lzd_norm_stage.sv
// ============================================================================
// Module  : lzd_norm_stage
// Purpose : Two-stage post-adder normalization with valid/ready handshake.
//           S1 captures the sum/carry and counts leading zeros; S2 applies
//           a left normalize shift, or a one-bit right shift on carry-out.
// Ports   : clk, rst (async, active-high)
//           valid_i/ready_o, Sum_i[SWR-1:0], Carry_i       upstream side
//           valid_o/ready_i, Norm_Sum_o[SWR-1:0],
//           LZ_Count_o[EWR-1:0], Shift_Right_o, Zero_o     downstream side
//           Sticky_o  (only when LZD_STICKY_EN is defined) bit shifted out
//                     on a carry right shift
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module lzd_norm_stage
   import lzd_norm_stage_pkg::*;
#(
   parameter int SWR = SWR_DEFAULT,
   parameter int EWR = EWR_DEFAULT
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           valid_i,
   output logic           ready_o,
   input  logic [SWR-1:0] Sum_i,
   input  logic           Carry_i,
   output logic           valid_o,
   input  logic           ready_i,
   output logic [SWR-1:0] Norm_Sum_o,
   output logic [EWR-1:0] LZ_Count_o,
   output logic           Shift_Right_o,
   output logic           Zero_o
`ifdef LZD_STICKY_EN
   ,
   output logic           Sticky_o
`endif
);

   // The all-zero count SWR must be representable in EWR bits
   generate
      if (EWR < lz_count_width(SWR)) begin : g_ewr_check
         $error("lzd_norm_stage: EWR too narrow, need 2**EWR-1 >= SWR");
      end
   endgenerate

   // ---------------------------------------------------------------- control
   logic s1_valid_q;
   logic valid_q;
   logic s2_adv;
   logic s1_adv;

   assign s2_adv  = !valid_q || ready_i;
   assign s1_adv  = !s1_valid_q || s2_adv;
   assign ready_o = s1_adv;
   assign valid_o = valid_q;

   // ---------------------------------------------------------------- stage 1
   logic [SWR-1:0] s1_sum_q;
   logic           s1_carry_q;
   logic [EWR-1:0] s1_lz_q;
   logic           s1_zero_q;
   logic [EWR-1:0] lz_w;
   logic           zero_w;

   lzd_count #(
      .SWR (SWR),
      .EWR (EWR)
   ) u_lzd_count (
      .data_i  (Sum_i),
      .count_o (lz_w),
      .zero_o  (zero_w)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid_q <= 1'b0;
         s1_sum_q   <= '0;
         s1_carry_q <= 1'b0;
         s1_lz_q    <= '0;
         s1_zero_q  <= 1'b0;
      end else if (s1_adv) begin
         s1_valid_q <= valid_i;
         if (valid_i) begin
            s1_sum_q   <= Sum_i;
            s1_carry_q <= Carry_i;
            s1_lz_q    <= lz_w;
            s1_zero_q  <= zero_w;
         end
      end
   end

   // ---------------------------------------------------------------- stage 2
   logic [SWR-1:0] norm_d,  norm_q;
   logic [EWR-1:0] lz_d,    lz_q;
   logic           sr_d,    sr_q;
   logic           zero_d,  zero_q;

   always_comb begin
      norm_d = s1_sum_q << s1_lz_q;
      lz_d   = s1_lz_q;
      sr_d   = 1'b0;
      zero_d = 1'b0;
      if (s1_carry_q) begin
         norm_d = {1'b1, s1_sum_q[SWR-1:1]};
         lz_d   = '0;
         sr_d   = 1'b1;
      end else if (s1_zero_q) begin
         // Encoder already reports SWR for an all-zero word
         norm_d = '0;
         zero_d = 1'b1;
      end
   end

   // Output data only updates when a valid result moves in, so bubbles
   // leave the held values untouched.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q <= 1'b0;
         norm_q  <= '0;
         lz_q    <= '0;
         sr_q    <= 1'b0;
         zero_q  <= 1'b0;
      end else if (s2_adv) begin
         valid_q <= s1_valid_q;
         if (s1_valid_q) begin
            norm_q <= norm_d;
            lz_q   <= lz_d;
            sr_q   <= sr_d;
            zero_q <= zero_d;
         end
      end
   end

   assign Norm_Sum_o    = norm_q;
   assign LZ_Count_o    = lz_q;
   assign Shift_Right_o = sr_q;
   assign Zero_o        = zero_q;

`ifdef LZD_STICKY_EN
   logic sticky_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sticky_q <= 1'b0;
      end else if (s2_adv && s1_valid_q) begin
         sticky_q <= s1_carry_q & s1_sum_q[0];
      end
   end

   assign Sticky_o = sticky_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_lzd_norm_stage.sv
`default_nettype none

module tb_lzd_norm_stage;
   import lzd_norm_stage_pkg::*;

   localparam int SWR = SWR_DEFAULT;
   localparam int EWR = EWR_DEFAULT;

   logic           clk = 1'b0;
   logic           rst;
   logic           valid_i;
   logic           ready_o;
   logic [SWR-1:0] Sum_i;
   logic           Carry_i;
   logic           valid_o;
   logic           ready_i;
   logic [SWR-1:0] Norm_Sum_o;
   logic [EWR-1:0] LZ_Count_o;
   logic           Shift_Right_o;
   logic           Zero_o;
`ifdef LZD_STICKY_EN
   logic           Sticky_o;
`endif

   int n_checks = 0;
   int n_pass   = 0;
   norm_res_t exp_q[$];

   always #5 clk = ~clk;

   lzd_norm_stage #(.SWR(SWR), .EWR(EWR)) dut (
      .clk           (clk),
      .rst           (rst),
      .valid_i       (valid_i),
      .ready_o       (ready_o),
      .Sum_i         (Sum_i),
      .Carry_i       (Carry_i),
      .valid_o       (valid_o),
      .ready_i       (ready_i),
      .Norm_Sum_o    (Norm_Sum_o),
      .LZ_Count_o    (LZ_Count_o),
      .Shift_Right_o (Shift_Right_o),
      .Zero_o        (Zero_o)
`ifdef LZD_STICKY_EN
      ,
      .Sticky_o      (Sticky_o)
`endif
   );

   // Reference normalize model in plain arithmetic
   function automatic norm_res_t ref_norm(input logic [SWR-1:0] sum, input logic carry);
      norm_res_t r;
      longint    v;
      int        lz;
      r = '0;
      if (carry) begin
         // (sum + 2^SWR) / 2 places the carry in the MSB and drops sum[0]
         r.norm_sum    = SWR'((longint'(sum) + (longint'(1) << SWR)) / 2);
         r.shift_right = 1'b1;
`ifdef LZD_STICKY_EN
         r.sticky      = sum[0];
`endif
      end else if (sum == '0) begin
         r.lz_count = EWR'(SWR);
         r.zero     = 1'b1;
      end else begin
         v  = longint'(sum);
         lz = 0;
         while (v < (longint'(1) << (SWR - 1))) begin
            v  = v * 2;
            lz = lz + 1;
         end
         r.norm_sum = SWR'(v);
         r.lz_count = EWR'(lz);
      end
      return r;
   endfunction

   function automatic norm_res_t got_res();
      norm_res_t r;
      r.norm_sum    = Norm_Sum_o;
      r.lz_count    = LZ_Count_o;
      r.shift_right = Shift_Right_o;
      r.zero        = Zero_o;
`ifdef LZD_STICKY_EN
      r.sticky      = Sticky_o;
`else
      r.sticky      = 1'b0;
`endif
      return r;
   endfunction

   task automatic test_reset();
      rst = 1'b1; valid_i = 1'b0; ready_i = 1'b0; Sum_i = '0; Carry_i = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      n_checks++;
      if (valid_o !== 1'b0) $display("FAIL reset_valid: got %b want 0", valid_o);
      else n_pass++;
      n_checks++;
      if (got_res() !== norm_res_t'(0)) $display("FAIL reset_outputs: got %h want 0", got_res());
      else n_pass++;
      n_checks++;
      if (ready_o !== 1'b1) $display("FAIL reset_ready: got %b want 1", ready_o);
      else n_pass++;
      rst = 1'b0;
   endtask

   task automatic test_single(input logic [SWR-1:0] sum, input logic carry,
                              input logic [SWR-1:0] e_norm, input int e_lz,
                              input logic e_sr, input logic e_zero, input logic e_sticky,
                              input string name);
      @(posedge clk); #1;
      valid_i = 1'b1; Sum_i = sum; Carry_i = carry; ready_i = 1'b1;
      @(posedge clk); #1;
      valid_i = 1'b0;
      n_checks++;
      if (valid_o !== 1'b0) $display("FAIL %s_latency1: valid_o got %b want 0", name, valid_o);
      else n_pass++;
      @(posedge clk); #1;
      n_checks++;
      if (valid_o !== 1'b1) $display("FAIL %s_valid: got %b want 1", name, valid_o);
      else n_pass++;
      n_checks++;
      if ({Norm_Sum_o, LZ_Count_o, Shift_Right_o, Zero_o} !== {e_norm, EWR'(e_lz), e_sr, e_zero})
         $display("FAIL %s_result: got norm=%h lz=%0d sr=%b z=%b want norm=%h lz=%0d sr=%b z=%b",
                  name, Norm_Sum_o, LZ_Count_o, Shift_Right_o, Zero_o, e_norm, e_lz, e_sr, e_zero);
      else n_pass++;
`ifdef LZD_STICKY_EN
      n_checks++;
      if (Sticky_o !== e_sticky) $display("FAIL %s_sticky: got %b want %b", name, Sticky_o, e_sticky);
      else n_pass++;
`else
      if (e_sticky === 1'bx) $display("note: sticky unknown");
`endif
      @(posedge clk); #1;
   endtask

   task automatic test_back_to_back();
      logic [SWR-1:0] sums [8];
      logic           carries [8];
      int             sent = 0;
      int             got = 0;
      logic           seen_drop = 1'b0;
      logic           prev_hold = 1'b0;
      norm_res_t      prev_res;
      norm_res_t      exp;
      for (int k = 0; k < 8; k++) begin
         sums[k]    = SWR'($urandom) >> $urandom_range(0, 8);
         carries[k] = (k % 3 == 1);
      end
      for (int c = 0; c < 60 && got < 8; c++) begin
         @(posedge clk); #1;
         if (prev_hold) begin
            n_checks++;
            if (valid_o !== 1'b1 || got_res() !== prev_res)
               $display("FAIL stall_hold: got v=%b %h want v=1 %h", valid_o, got_res(), prev_res);
            else n_pass++;
         end
         valid_i = (sent < 8);
         if (sent < 8) begin Sum_i = sums[sent]; Carry_i = carries[sent]; end
         ready_i = !(c >= 3 && c <= 5);
         #1;
         if (!ready_o) seen_drop = 1'b1;
         if (valid_i && ready_o) begin
            exp_q.push_back(ref_norm(Sum_i, Carry_i));
            sent++;
         end
         if (valid_o && ready_i) begin
            n_checks++;
            if (exp_q.size() == 0) $display("FAIL b2b_extra: got %h want none", got_res());
            else begin
               exp = exp_q.pop_front();
               if (got_res() !== exp) $display("FAIL b2b_result%0d: got %h want %h", got, got_res(), exp);
               else n_pass++;
            end
            got++;
         end
         prev_hold = valid_o && !ready_i;
         prev_res  = got_res();
      end
      valid_i = 1'b0;
      n_checks++;
      if (got != 8) $display("FAIL b2b_count: got %0d want 8", got);
      else n_pass++;
      n_checks++;
      if (seen_drop !== 1'b1) $display("FAIL b2b_ready_drop: got %b want 1", seen_drop);
      else n_pass++;
      exp_q.delete();
   endtask

   task automatic test_reset_midstream();
      @(posedge clk); #1;
      ready_i = 1'b0; valid_i = 1'b1; Sum_i = SWR'($urandom); Carry_i = 1'b0;
      @(posedge clk); #1;
      Sum_i = SWR'($urandom); Carry_i = 1'b1;
      @(posedge clk); #1;
      valid_i = 1'b0;
      n_checks++;
      if (valid_o !== 1'b1 || ready_o !== 1'b0)
         $display("FAIL mid_full: got valid_o=%b ready_o=%b want 1 0", valid_o, ready_o);
      else n_pass++;
      rst = 1'b1;
      #1;
      n_checks++;
      if (valid_o !== 1'b0 || got_res() !== norm_res_t'(0) || ready_o !== 1'b1)
         $display("FAIL mid_reset: got v=%b %h rdy=%b want 0 0 1", valid_o, got_res(), ready_o);
      else n_pass++;
      @(posedge clk); #1;
      rst = 1'b0; ready_i = 1'b1;
      for (int c = 0; c < 4; c++) begin
         @(posedge clk); #1;
         n_checks++;
         if (valid_o !== 1'b0) $display("FAIL mid_stale%0d: got valid_o=%b want 0", c, valid_o);
         else n_pass++;
      end
   endtask

   task automatic test_random();
      norm_res_t exp;
      int        shift;
      for (int c = 0; c < 10060; c++) begin
         @(posedge clk); #1;
         if (valid_o && !Zero_o) begin
            n_checks++;
            if (Norm_Sum_o[SWR-1] !== 1'b1) $display("FAIL rnd_msb: got %h want msb 1", Norm_Sum_o);
            else n_pass++;
         end
         valid_i = (c < 10000) && ($urandom_range(0, 3) != 0);
         shift   = $urandom_range(0, SWR);
         Sum_i   = SWR'($urandom) >> shift;
         Carry_i = ($urandom_range(0, 3) == 0);
         ready_i = (c >= 10000) || ($urandom_range(0, 3) != 0);
         #1;
         if (valid_i && ready_o) exp_q.push_back(ref_norm(Sum_i, Carry_i));
         if (valid_o && ready_i) begin
            n_checks++;
            if (exp_q.size() == 0) $display("FAIL rnd_extra: got %h want none", got_res());
            else begin
               exp = exp_q.pop_front();
               if (got_res() !== exp) $display("FAIL rnd_result: got %h want %h", got_res(), exp);
               else n_pass++;
            end
         end
      end
      valid_i = 1'b0;
      n_checks++;
      if (exp_q.size() != 0) $display("FAIL rnd_drain: got %0d pending want 0", exp_q.size());
      else n_pass++;
   endtask

   initial begin
      test_reset();
      test_single(26'h0800000, 1'b0, 26'h2000000, 2,  1'b0, 1'b0, 1'b0, "lz2");
      test_single(26'h0000003, 1'b1, 26'h2000001, 0,  1'b1, 1'b0, 1'b1, "carry");
      test_single(26'h0000000, 1'b0, 26'h0000000, 26, 1'b0, 1'b1, 1'b0, "zero");
      test_single(26'h0000001, 1'b0, 26'h2000000, 25, 1'b0, 1'b0, 1'b0, "lz25");
      test_back_to_back();
      test_reset_midstream();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

`default_nettype wire
